step_phase_decoder: RTL and testbench
=====================================

Name: step_phase_decoder

Overview:
- Monitors the four stepper coil lines {A1,B1,A2,B2} driven by the motor driver and reconstructs motion from the phase sequence.
- Reports signed position, last direction, a per-step pulse and sticky fault flags for illegal patterns or skipped phases.
- Sits beside the driver on the rail-control FPGA and closes the loop for the controller and the VGA status display.
- Coil lines are asynchronous to clk and are synchronised internally.

Parameters:
- POS_W, 16: width of the signed position counter.
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before a coil pattern is accepted (min 1).
- TIMEOUT_CYC, 2000000: stall timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- A1  in  1  coil A+ line, async.
- B1  in  1  coil B+ line, async.
- A2  in  1  coil A- line, async.
- B2  in  1  coil B- line, async.
- clr_err  in  1  synchronous pulse; clears fault flags, returns FSM to IDLE.
- clr_pos  in  1  synchronous pulse; zeroes position.
- position  out  POS_W  signed step count; forward +1, backward -1.
- step_pulse  out  1  one-cycle pulse per accepted step.
- dir  out  1  direction of the last accepted step: 1 forward, 0 backward.
- energised  out  1  accepted pattern is a valid phase (not 0000).
- fault_illegal  out  1  sticky; accepted pattern outside the legal set.
- fault_skip  out  1  sticky; two-phase jump detected.
- stalled  out  1  stall flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; filter counter 0; sync flops 0.
- Synchroniser: 2-flop sync on each coil line; all downstream logic uses the synchronised 4-bit vector P = {A1,B1,A2,B2}.
- Filter:
  - A candidate register holds the last sampled P.
  - If P equals the candidate, the counter increments, saturating at STABLE_CYCLES; otherwise the candidate is loaded with P and the counter resets to 1.
  - A pattern is accepted in the cycle the counter reaches STABLE_CYCLES and differs from the last accepted pattern.
  - Each distinct stable pattern is accepted exactly once.
- Decode:
  - Legal phases: 1100=ph0, 0110=ph1, 0011=ph2, 1001=ph3.
  - 0000 = de-energised.
  - Any other pattern = illegal.
- FSM states IDLE, TRACK, FAULT:
  - IDLE, accept phase k: store k, go to TRACK. No step counted.
  - IDLE, accept 0000: stay in IDLE.
  - IDLE, accept illegal: set fault_illegal, go to FAULT.
  - TRACK, new phase = prev+1 mod 4: position +1, dir=1, step_pulse.
  - TRACK, new phase = prev-1 mod 4: position -1, dir=0, step_pulse.
  - TRACK, new phase = prev+2 mod 4: set fault_skip, go to FAULT, position unchanged.
  - TRACK, accept 0000: go to IDLE; position and dir are held.
  - TRACK, accept illegal: set fault_illegal, go to FAULT.
  - FAULT: ignores all accepted patterns; position frozen. clr_err sends it to IDLE and clears both fault flags.
- Wrap-around: ph3 -> ph0 counts forward; ph0 -> ph3 counts backward.
- Position arithmetic: two's-complement, wraps modulo 2^POS_W with no saturation.
- Latency: a coil change held stable produces step_pulse and the updated position 2 + STABLE_CYCLES + 1 clk cycles after it appears at the pins.
- energised: registered; reflects the last accepted pattern.
- Simultaneous events:
  - clr_pos and step in the same cycle: clr_pos wins, position = 0; step_pulse still fires and dir still updates.
  - clr_err while a new fault is detected in the same cycle: the fault wins and the flag stays set.
- Reset mid-operation clears everything. After release, the first accepted phase is treated as the reference (IDLE -> TRACK) and is not counted.

Optional Feature:
- Macro: STEP_DEC_STALL_EN.
- Defined:
  - A counter runs while the FSM is in TRACK; it resets on every accepted pattern.
  - When it reaches TIMEOUT_CYC, stalled is set. stalled clears on the next step_pulse, on leaving TRACK, on clr_err or on reset.
  - stalled does not move the FSM to FAULT.
- Not defined: no counter is built and stalled is driven constant 0.

Test Plan:
- Reset, then drive 1100,0110,0011,1001,1100, each held 20 cycles -> 4 step_pulses, position=4, dir=1, no faults.
- From ph0, drive 1001,0011,0110,1100 -> position goes 0,-1,-2,-3,-4 (0xFFFC at POS_W=16), dir=0.
- In TRACK at ph0, drive 0011 -> fault_skip=1, FSM in FAULT, position unchanged; further legal phases are ignored; clr_err -> flags 0, IDLE; the next phase is not counted.
- Drive 1010 for 20 cycles -> fault_illegal=1. Drive a 1-cycle glitch 1111 inside a stable 0110 with STABLE_CYCLES=4 -> no fault, no step.
- Preload position 0x7FFF, step forward -> 0x8000. Assert clr_pos in the same cycle as a step -> position 0, step_pulse=1.
- With STEP_DEC_STALL_EN and TIMEOUT_CYC=100: hold ph1 for 150 cycles -> stalled=1 at cycle 100 after acceptance; the next step clears it. Without the macro -> stalled stays 0.

Source files
------------

// File: rtl/step_phase_decoder.sv
// Stepper coil phase decoder: synchronises {A1,B1,A2,B2}, debounces, tracks position/direction and latches faults.
// Optional stall detector is built when STEP_DEC_STALL_EN is defined.
module step_phase_decoder #(
   parameter int POS_W         = 16,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_CYC   = 2000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             A1,
   input  logic             B1,
   input  logic             A2,
   input  logic             B2,
   input  logic             clr_err,
   input  logic             clr_pos,
   output logic [POS_W-1:0] position,
   output logic             step_pulse,
   output logic             dir,
   output logic             energised,
   output logic             fault_illegal,
   output logic             fault_skip,
   output logic             stalled
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Returns {legal, de-energised, phase[1:0]} for a coil pattern.
   function automatic logic [3:0] decode_phase(input logic [3:0] p);
      case (p)
         4'b1100: decode_phase = 4'b1000;
         4'b0110: decode_phase = 4'b1001;
         4'b0011: decode_phase = 4'b1010;
         4'b1001: decode_phase = 4'b1011;
         4'b0000: decode_phase = 4'b0100;
         default: decode_phase = 4'b0000;
      endcase
   endfunction

   logic [3:0]       meta_r, sync_r, cand_r, acc_r;
   logic [CNT_W-1:0] cnt_r;
   state_t           state_r, state_n;
   logic [1:0]       phase_r, phase_n;
   logic [POS_W-1:0] position_r, pos_n;
   logic             dir_r, dir_n;
   logic             step_pulse_r, step_s;
   logic             energised_r, energ_n;
   logic             fault_illegal_r, fill_n;
   logic             fault_skip_r, fskip_n;
   logic             new_fault_s;
   logic             accept_s;
   logic [3:0]       dec_s;
   logic             dec_legal_s, dec_zero_s;
   logic [1:0]       dec_ph_s, diff_s;

   // Two-flop synchroniser on the coil lines.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= 4'b0000;
         sync_r <= 4'b0000;
      end else begin
         meta_r <= {A1, B1, A2, B2};
         sync_r <= meta_r;
      end
   end

   // Stability filter: candidate pattern plus saturating match counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_r <= 4'b0000;
         cnt_r  <= {CNT_W{1'b0}};
      end else if (sync_r == cand_r) begin
         if (cnt_r != STABLE_V) begin
            cnt_r <= cnt_r + 1'b1;
         end
      end else begin
         cand_r <= sync_r;
         cnt_r  <= CNT_W'(1);
      end
   end

   // A stable candidate that differs from the last accepted pattern is accepted once.
   assign accept_s    = (cnt_r == STABLE_V) && (cand_r != acc_r);
   assign dec_s       = decode_phase(cand_r);
   assign dec_legal_s = dec_s[3];
   assign dec_zero_s  = dec_s[2];
   assign dec_ph_s    = dec_s[1:0];
   assign diff_s      = dec_ph_s - phase_r;

   // Next-state, position and flag logic.
   always_comb begin
      state_n     = state_r;
      phase_n     = phase_r;
      pos_n       = position_r;
      dir_n       = dir_r;
      step_s      = 1'b0;
      fill_n      = fault_illegal_r;
      fskip_n     = fault_skip_r;
      new_fault_s = 1'b0;
      energ_n     = accept_s ? dec_legal_s : energised_r;

      case (state_r)
         IDLE: begin
            if (accept_s && dec_legal_s) begin
               phase_n = dec_ph_s;
               state_n = TRACK;
            end else if (accept_s && !dec_zero_s) begin
               fill_n      = 1'b1;
               new_fault_s = 1'b1;
               state_n     = FAULT;
            end else begin
               state_n = IDLE;
            end
         end
         TRACK: begin
            if (accept_s && dec_legal_s) begin
               phase_n = dec_ph_s;
               case (diff_s)
                  2'd1: begin
                     pos_n  = position_r + POS_W'(1);
                     dir_n  = 1'b1;
                     step_s = 1'b1;
                  end
                  2'd3: begin
                     pos_n  = position_r - POS_W'(1);
                     dir_n  = 1'b0;
                     step_s = 1'b1;
                  end
                  2'd2: begin
                     phase_n     = phase_r;
                     fskip_n     = 1'b1;
                     new_fault_s = 1'b1;
                     state_n     = FAULT;
                  end
                  default: phase_n = phase_r;
               endcase
            end else if (accept_s && dec_zero_s) begin
               state_n = IDLE;
            end else if (accept_s) begin
               fill_n      = 1'b1;
               new_fault_s = 1'b1;
               state_n     = FAULT;
            end else begin
               state_n = TRACK;
            end
         end
         FAULT:   state_n = FAULT;
         default: state_n = IDLE;
      endcase

      // A fault detected in the same cycle beats clr_err.
      if (clr_err && !new_fault_s) begin
         state_n = IDLE;
         fill_n  = 1'b0;
         fskip_n = 1'b0;
      end else begin
         fill_n  = fill_n;
         fskip_n = fskip_n;
      end

      if (clr_pos) begin
         pos_n = {POS_W{1'b0}};
      end else begin
         pos_n = pos_n;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= IDLE;
         phase_r         <= 2'd0;
         acc_r           <= 4'b0000;
         position_r      <= {POS_W{1'b0}};
         dir_r           <= 1'b0;
         step_pulse_r    <= 1'b0;
         energised_r     <= 1'b0;
         fault_illegal_r <= 1'b0;
         fault_skip_r    <= 1'b0;
      end else begin
         state_r         <= state_n;
         phase_r         <= phase_n;
         acc_r           <= accept_s ? cand_r : acc_r;
         position_r      <= pos_n;
         dir_r           <= dir_n;
         step_pulse_r    <= step_s;
         energised_r     <= energ_n;
         fault_illegal_r <= fill_n;
         fault_skip_r    <= fskip_n;
      end
   end

   assign position      = position_r;
   assign step_pulse    = step_pulse_r;
   assign dir           = dir_r;
   assign energised     = energised_r;
   assign fault_illegal = fault_illegal_r;
   assign fault_skip    = fault_skip_r;

`ifdef STEP_DEC_STALL_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT_CYC);

   logic [TO_W-1:0] stall_cnt_r;
   logic            stalled_r;

   // Stall timer: counts idle TRACK cycles, restarts on every accepted pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= {TO_W{1'b0}};
         stalled_r   <= 1'b0;
      end else begin
         if (accept_s || state_r != TRACK) begin
            stall_cnt_r <= {TO_W{1'b0}};
         end else if (stall_cnt_r != TIMEOUT_V) begin
            stall_cnt_r <= stall_cnt_r + 1'b1;
         end
         if (step_s || state_n != TRACK || clr_err) begin
            stalled_r <= 1'b0;
         end else if (state_r == TRACK && !accept_s && stall_cnt_r == TIMEOUT_V - 1'b1) begin
            stalled_r <= 1'b1;
         end
      end
   end

   assign stalled = stalled_r;
`else
   assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed self-checking bench for step_phase_decoder; a second instance with POS_W=4 exercises counter wrap.
module tb_step_phase_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        A1 = 1'b0, B1 = 1'b0, A2 = 1'b0, B2 = 1'b0;
   logic        clr_err = 1'b0, clr_pos = 1'b0;
   logic [15:0] position;
   logic        step_pulse, dir, energised, fault_illegal, fault_skip, stalled;
   logic [3:0]  position_w;
   logic        step_pulse_w, dir_w, energised_w, fault_illegal_w, fault_skip_w, stalled_w;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

`ifdef STEP_DEC_STALL_EN
   localparam logic STALL_EXP = 1'b1;
`else
   localparam logic STALL_EXP = 1'b0;
`endif

   step_phase_decoder #(.POS_W(16), .STABLE_CYCLES(4), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset), .A1(A1), .B1(B1), .A2(A2), .B2(B2),
      .clr_err(clr_err), .clr_pos(clr_pos), .position(position), .step_pulse(step_pulse),
      .dir(dir), .energised(energised), .fault_illegal(fault_illegal),
      .fault_skip(fault_skip), .stalled(stalled)
   );

   step_phase_decoder #(.POS_W(4), .STABLE_CYCLES(4), .TIMEOUT_CYC(100)) dut_w (
      .clk(clk), .reset(reset), .A1(A1), .B1(B1), .A2(A2), .B2(B2),
      .clr_err(clr_err), .clr_pos(clr_pos), .position(position_w), .step_pulse(step_pulse_w),
      .dir(dir_w), .energised(energised_w), .fault_illegal(fault_illegal_w),
      .fault_skip(fault_skip_w), .stalled(stalled_w)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (step_pulse === 1'b1) pulse_cnt++;
   end

   task automatic drive(input logic [3:0] p, input int n);
      {A1, B1, A2, B2} = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr_err();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {A1, B1, A2, B2} = 4'b0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({position, step_pulse, dir, energised, fault_illegal, fault_skip, stalled} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs got pos=%h sp=%b dir=%b en=%b fi=%b fs=%b st=%b want all 0",
                  position, step_pulse, dir, energised, fault_illegal, fault_skip, stalled);
      end
      do_reset();
   endtask

   task automatic test_forward();
      int base;
      drive(4'b1100, 20);
      base = pulse_cnt;
      drive(4'b0110, 20); drive(4'b0011, 20); drive(4'b1001, 20); drive(4'b1100, 20);
      checks++;
      if (pulse_cnt - base !== 4) begin errors++; $display("FAIL fwd_pulses got %0d want 4", pulse_cnt - base); end
      checks++;
      if (position !== 16'h0004) begin errors++; $display("FAIL fwd_pos got %h want 0004", position); end
      checks++;
      if ({dir, fault_illegal, fault_skip, energised} !== 4'b1001) begin
         errors++; $display("FAIL fwd_flags got dir/fi/fs/en=%b want 1001", {dir, fault_illegal, fault_skip, energised});
      end
   endtask

   task automatic test_reset_mid();
      int base;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({position, dir, energised} !== 18'd0) begin
         errors++; $display("FAIL midreset_clear got pos=%h dir=%b en=%b want 0", position, dir, energised);
      end
      reset = 1'b0;
      base = pulse_cnt;
      drive(4'b0011, 20);
      checks++;
      if (position !== 16'h0000 || pulse_cnt != base) begin
         errors++; $display("FAIL midreset_ref got pos=%h pulses=%0d want 0000 0", position, pulse_cnt - base);
      end
      drive(4'b1001, 20);
      checks++;
      if (position !== 16'h0001) begin errors++; $display("FAIL midreset_step got %h want 0001", position); end
   endtask

   task automatic test_backward();
      logic [15:0] exp_pos [4] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};
      logic [3:0]  pats    [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};
      do_reset();
      drive(4'b1100, 20);
      for (int i = 0; i < 4; i++) begin
         drive(pats[i], 20);
         checks++;
         if (position !== exp_pos[i]) begin
            errors++; $display("FAIL bwd_pos[%0d] got %h want %h", i, position, exp_pos[i]);
         end
      end
      checks++;
      if (dir !== 1'b0 || position_w !== 4'hC) begin
         errors++; $display("FAIL bwd_dir got dir=%b posw=%h want 0 c", dir, position_w);
      end
   endtask

   task automatic test_skip();
      int base;
      drive(4'b0011, 20);
      checks++;
      if ({fault_skip, fault_illegal} !== 2'b10 || position !== 16'hFFFC) begin
         errors++; $display("FAIL skip_detect got fs=%b fi=%b pos=%h want 1 0 fffc", fault_skip, fault_illegal, position);
      end
      base = pulse_cnt;
      drive(4'b0110, 20); drive(4'b1100, 20);
      checks++;
      if (position !== 16'hFFFC || pulse_cnt != base || fault_skip !== 1'b1) begin
         errors++; $display("FAIL skip_frozen got pos=%h pulses=%0d fs=%b want fffc 0 1", position, pulse_cnt - base, fault_skip);
      end
      pulse_clr_err();
      checks++;
      if ({fault_skip, fault_illegal} !== 2'b00) begin
         errors++; $display("FAIL skip_clear got fs=%b fi=%b want 0 0", fault_skip, fault_illegal);
      end
      drive(4'b0110, 20);
      checks++;
      if (position !== 16'hFFFC || pulse_cnt != base) begin
         errors++; $display("FAIL skip_ref got pos=%h pulses=%0d want fffc 0", position, pulse_cnt - base);
      end
      drive(4'b0011, 20);
      checks++;
      if (position !== 16'hFFFD || dir !== 1'b1) begin
         errors++; $display("FAIL skip_resume got pos=%h dir=%b want fffd 1", position, dir);
      end
   endtask

   task automatic test_deenergise();
      drive(4'b0000, 20);
      checks++;
      if (energised !== 1'b0 || position !== 16'hFFFD || dir !== 1'b1) begin
         errors++; $display("FAIL deen_hold got en=%b pos=%h dir=%b want 0 fffd 1", energised, position, dir);
      end
      drive(4'b0110, 20);
      checks++;
      if (energised !== 1'b1 || position !== 16'hFFFD) begin
         errors++; $display("FAIL deen_ref got en=%b pos=%h want 1 fffd", energised, position);
      end
      drive(4'b1100, 20);
      checks++;
      if (position !== 16'hFFFC || dir !== 1'b0) begin
         errors++; $display("FAIL deen_back got pos=%h dir=%b want fffc 0", position, dir);
      end
   endtask

   task automatic test_illegal_glitch();
      int base;
      drive(4'b1010, 20);
      checks++;
      if (fault_illegal !== 1'b1 || energised !== 1'b0) begin
         errors++; $display("FAIL illegal_detect got fi=%b en=%b want 1 0", fault_illegal, energised);
      end
      pulse_clr_err();
      checks++;
      if (fault_illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b want 0", fault_illegal); end
      drive(4'b0110, 20);
      base = pulse_cnt;
      drive(4'b1111, 1);
      drive(4'b0110, 20);
      checks++;
      if (fault_illegal !== 1'b0 || fault_skip !== 1'b0 || pulse_cnt != base || position !== 16'hFFFC) begin
         errors++; $display("FAIL glitch got fi=%b fs=%b pulses=%0d pos=%h want 0 0 0 fffc",
                            fault_illegal, fault_skip, pulse_cnt - base, position);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] pats [7] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001};
      do_reset();
      drive(4'b1100, 20);
      for (int i = 0; i < 7; i++) drive(pats[i], 20);
      checks++;
      if (position_w !== 4'h7) begin errors++; $display("FAIL wrap_pre got %h want 7", position_w); end
      drive(4'b1100, 20);
      checks++;
      if (position_w !== 4'h8 || position !== 16'h0008) begin
         errors++; $display("FAIL wrap_post got posw=%h pos=%h want 8 0008", position_w, position);
      end
   endtask

   task automatic test_latency_clrpos();
      int lat = 0;
      {A1, B1, A2, B2} = 4'b0110;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(negedge clk);
         if (step_pulse === 1'b1) lat = n;
         else if (n == 6) clr_pos = 1'b1;
      end
      checks++;
      if (lat != 7) begin errors++; $display("FAIL latency got %0d want 7", lat); end
      checks++;
      if (position !== 16'h0000 || step_pulse !== 1'b1 || dir !== 1'b1) begin
         errors++; $display("FAIL clrpos_step got pos=%h sp=%b dir=%b want 0000 1 1", position, step_pulse, dir);
      end
      clr_pos = 1'b0;
      repeat (15) @(negedge clk);
      drive(4'b0011, 20);
      checks++;
      if (position !== 16'h0001) begin errors++; $display("FAIL clrpos_after got %h want 0001", position); end
   endtask

   task automatic test_clr_err_vs_fault();
      {A1, B1, A2, B2} = 4'b1100;
      repeat (6) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (fault_skip !== 1'b1 || position !== 16'h0001) begin
         errors++; $display("FAIL clrerr_vs_fault got fs=%b pos=%h want 1 0001", fault_skip, position);
      end
      pulse_clr_err();
      checks++;
      if (fault_skip !== 1'b0) begin errors++; $display("FAIL clrerr_after got %b want 0", fault_skip); end
   endtask

   task automatic test_stall();
      {A1, B1, A2, B2} = 4'b0110;
      repeat (7 + 99) @(negedge clk);
      checks++;
      if (stalled !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", stalled); end
      @(negedge clk);
      checks++;
      if (stalled !== STALL_EXP) begin errors++; $display("FAIL stall_set got %b want %b", stalled, STALL_EXP); end
      repeat (49) @(negedge clk);
      checks++;
      if (stalled !== STALL_EXP) begin errors++; $display("FAIL stall_hold got %b want %b", stalled, STALL_EXP); end
      drive(4'b0011, 20);
      checks++;
      if (stalled !== 1'b0 || position !== 16'h0002) begin
         errors++; $display("FAIL stall_clear got st=%b pos=%h want 0 0002", stalled, position);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reset_mid();
      test_backward();
      test_skip();
      test_deenergise();
      test_illegal_glitch();
      test_wrap();
      test_latency_clrpos();
      test_clr_err_vs_fault();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule
